// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit Q and R.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_divider #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] N,
  input  logic [W-1:0]   D,
  output logic [W-1:0]   Q,
  output logic [W-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam int unsigned CW = $clog2(2 * W);
  localparam logic [CW-1:0] LastIter = CW'(2 * W - 1);

  typedef enum logic [2:0] {StIdle, StCalc, StFix, StZero, StDone} state_e;

  state_e         state_q, state_d;
  logic [2*W-1:0] nq_q;   // dividend magnitude, shifted out MSB first; quotient shifts in at LSB
  logic [W-1:0]   dm_q;
  logic [W-1:0]   rem_q;
  logic [CW-1:0]  cnt_q;

  logic [2*W-1:0] n_mag;
  logic [W-1:0]   d_mag;
  logic [W:0]     shifted;
  logic           take;
  logic [W-1:0]   rem_d;
  logic           in_range;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [2*W-1:0] QNegMax = (2 * W)'(1) << (W - 1);
  logic sn_q, sd_q;

  always_comb begin
    n_mag    = N[2*W-1] ? (~N + (2 * W)'(1)) : N;
    d_mag    = D[W-1] ? (~D + W'(1)) : D;
    // Most negative quotient magnitude is only legal when the quotient is negative.
    in_range = (sn_q ^ sd_q) ? (nq_q <= QNegMax) : (nq_q < QNegMax);
    q_fix    = (sn_q ^ sd_q) ? (~nq_q[W-1:0] + W'(1)) : nq_q[W-1:0];
    r_fix    = sn_q ? (~rem_q + W'(1)) : rem_q;
  end
`else
  always_comb begin
    n_mag    = N;
    d_mag    = D;
    in_range = (nq_q[2*W-1:W] == '0);
    q_fix    = nq_q[W-1:0];
    r_fix    = rem_q;
  end
`endif

  always_comb begin
    shifted = {rem_q, nq_q[2*W-1]};
    take    = (shifted >= {1'b0, dm_q});
    rem_d   = take ? W'(shifted - {1'b0, dm_q}) : shifted[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = (D == '0) ? StZero : StCalc;
      StCalc: if (cnt_q == LastIter) state_d = StFix;
      StFix:  state_d = StDone;
      StZero: state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      nq_q  <= '0;
      dm_q  <= '0;
      rem_q <= '0;
      cnt_q <= '0;
`ifdef SEQ_DIV_SIGNED_EN
      sn_q  <= 1'b0;
      sd_q  <= 1'b0;
`endif
    end else begin
      // done is raised as DONE is left, so it is visible while the FSM is back in IDLE.
      done <= (state_q == StDone);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy  <= 1'b1;
            nq_q  <= n_mag;
            dm_q  <= d_mag;
            rem_q <= '0;
            cnt_q <= '0;
`ifdef SEQ_DIV_SIGNED_EN
            sn_q  <= N[2*W-1];
            sd_q  <= D[W-1];
`endif
          end
        end
        StCalc: begin
          nq_q  <= {nq_q[2*W-2:0], take};
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
        end
        StFix: begin
          Q   <= in_range ? q_fix : '0;
          R   <= in_range ? r_fix : '0;
          ovf <= ~in_range;
        end
        StZero: begin
          Q   <= '0;
          R   <= '0;
          ovf <= 1'b1;
        end
        StDone: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
